// File: rtl/down_count_timer.sv
// Programmable down-counter: loads a start value, counts to zero on enabled
// falling edges, pulses tc at expiry, and optionally reloads for periodic ticks.
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_mode,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic             load_fire;

  // Load handshake: the source raises load_valid with load_value/load_mode
  // stable and holds them; the transfer happens on the falling edge where
  // load_valid and load_ready are both high. load_ready is low only while
  // counting, so a request made mid-count simply waits.
  assign load_ready = (state != COUNT);
  assign load_fire  = load_valid & load_ready;
  assign busy       = (state == COUNT);
  assign done       = (state == DONE);
  assign fsm_state  = state;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      q      <= '0;
      tc     <= 1'b0;
      reload <= '0;
      mode   <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load_fire) begin
            q      <= load_value;
            reload <= load_value;
            mode   <= load_mode;
            if (load_value != '0) begin
              state <= COUNT;
            end else begin
              // A zero load expires immediately and never reloads.
              tc    <= 1'b1;
              mode  <= 1'b0;
              state <= DONE;
            end
          end else if (abort && (state == DONE)) begin
            state <= IDLE;
          end
        end
        COUNT: begin
          if (abort) begin
            q     <= '0;
            state <= IDLE;
          end else if (enable) begin
            if (q > ONE) begin
              q <= q - ONE;
            end else if (q == ONE) begin
              q  <= '0;
              tc <= 1'b1;
              if (!mode) state <= DONE;
            end else if (mode) begin
              // Auto-reload dwells one enabled edge at zero, giving N+1 period.
              q <= reload;
            end else begin
              state <= DONE;
            end
          end
        end
        default: begin
          q     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_count_timer.sv
// Bench for down_count_timer: a WIDTH=4 and a WIDTH=8 instance, each checked
// every cycle against an elapsed-edge model, plus directed literal checks.
module tb_down_count_timer;

  logic       clk;
  logic       reset;

  logic       a_lv, a_ready, a_mode, a_en, a_abort, a_tc, a_busy, a_done;
  logic [3:0] a_val, a_q;
  logic [1:0] a_st;
  logic       b_lv, b_ready, b_mode, b_en, b_abort, b_tc, b_busy, b_done;
  logic [7:0] b_val, b_q;
  logic [1:0] b_st;

  int n_checks = 0;
  int n_fail   = 0;
  int tc_cnt4  = 0;

  down_count_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .load_valid(a_lv), .load_ready(a_ready),
    .load_value(a_val), .load_mode(a_mode), .enable(a_en), .abort(a_abort),
    .q(a_q), .tc(a_tc), .busy(a_busy), .done(a_done), .fsm_state(a_st)
  );

  down_count_timer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load_valid(b_lv), .load_ready(b_ready),
    .load_value(b_val), .load_mode(b_mode), .enable(b_en), .abort(b_abort),
    .q(b_q), .tc(b_tc), .busy(b_busy), .done(b_done), .fsm_state(b_st)
  );

  // Clock and reset: falling edges at 10, 20, ...; sampling on rising edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a run of N is "elapsed enabled edges since load"; q is derived from it.
  typedef struct {
    bit active;
    bit done;
    bit mode;
    bit tc;
    int n;
    int elapsed;
  } mdl_t;

  mdl_t m4, m8;

  function automatic mdl_t step(mdl_t m, bit lv, int val, bit md, bit en, bit ab);
    mdl_t r;
    r    = m;
    r.tc = 1'b0;
    if (!m.active) begin
      if (lv) begin
        r.n       = val;
        r.mode    = md;
        r.elapsed = 0;
        if (val == 0) begin
          r.tc   = 1'b1;
          r.done = 1'b1;
          r.mode = 1'b0;
        end else begin
          r.active = 1'b1;
          r.done   = 1'b0;
        end
      end else if (ab) begin
        r.done = 1'b0;
      end
    end else if (ab) begin
      r.active = 1'b0;
      r.done   = 1'b0;
    end else if (en) begin
      r.elapsed = m.elapsed + 1;
      if (r.elapsed % (r.n + 1) == r.n) begin
        r.tc = 1'b1;
        if (!r.mode) begin
          r.active = 1'b0;
          r.done   = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic int model_q(mdl_t m);
    return m.active ? (m.n - (m.elapsed % (m.n + 1))) : 0;
  endfunction

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      m4 = '{default: 0};
      m8 = '{default: 0};
    end else begin
      m4 = step(m4, a_lv, int'(a_val), a_mode, a_en, a_abort);
      m8 = step(m8, b_lv, int'(b_val), b_mode, b_en, b_abort);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: every rising edge, both instances against the model.
  always @(posedge clk) begin
    check("q4", int'(a_q), model_q(m4));
    check("tc4", int'(a_tc), int'(m4.tc));
    check("busy4", int'(a_busy), int'(m4.active));
    check("done4", int'(a_done), int'(m4.done));
    check("ready4", int'(a_ready), int'(!m4.active));
    check("q8", int'(b_q), model_q(m8));
    check("tc8", int'(b_tc), int'(m8.tc));
    check("busy8", int'(b_busy), int'(m8.active));
    check("done8", int'(b_done), int'(m8.done));
    check("ready8", int'(b_ready), int'(!m8.active));
    if (a_tc) tc_cnt4++;
  end

  // Driver tasks: all called at rising edge + 1.
  task automatic edge4(input bit en, input bit ab);
    a_en    = en;
    a_abort = ab;
    @(posedge clk);
    #1;
    a_abort = 1'b0;
  endtask

  task automatic do_load(input bit wide, input int val, input bit md);
    bit ok;
    ok = 1'b0;
    if (wide) begin
      b_val = val[7:0]; b_mode = md; b_lv = 1'b1;
    end else begin
      a_val = val[3:0]; a_mode = md; a_lv = 1'b1;
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = wide ? b_ready : a_ready;
      @(posedge clk);
      #1;
    end
    if (wide) b_lv = 1'b0;
    else a_lv = 1'b0;
    if (!ok) check("load_timeout", 0, 1);
  endtask

  task automatic t_reset_mid();
    do_load(0, 9, 0);
    repeat (3) edge4(1, 0);
    check("reset_pre_q", int'(a_q), 6);
    #2 reset = 1'b1;
    #1;
    check("reset_async_q", int'(a_q), 0);
    check("reset_async_busy", int'(a_busy), 0);
    check("reset_async_tc", int'(a_tc), 0);
    check("reset_async_ready", int'(a_ready), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    tc_cnt4 = 0;
    repeat (12) edge4(1, 0);
    check("reset_no_tc", tc_cnt4, 0);
  endtask

  task automatic t_one_shot();
    int exp_q[5] = '{4, 3, 2, 1, 0};
    do_load(0, 5, 0);
    check("oneshot_load_q", int'(a_q), 5);
    tc_cnt4 = 0;
    for (int i = 0; i < 5; i++) begin
      edge4(1, 0);
      check("oneshot_q", int'(a_q), exp_q[i]);
    end
    check("oneshot_tc", int'(a_tc), 1);
    check("oneshot_done", int'(a_done), 1);
    check("oneshot_busy", int'(a_busy), 0);
    check("oneshot_ready", int'(a_ready), 1);
    edge4(1, 0);
    check("oneshot_tc_count", tc_cnt4, 1);
  endtask

  task automatic t_auto_reload();
    int exp_q[12] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
    do_load(0, 3, 1);
    check("reload_load_q", int'(a_q), 3);
    tc_cnt4 = 0;
    a_val = 4'd7; a_mode = 1'b0; a_lv = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge4(1, 0);
      check("reload_q", int'(a_q), exp_q[i]);
      check("reload_ready", int'(a_ready), 0);
    end
    check("reload_tc_count", tc_cnt4, 3);
    edge4(1, 1);
    a_lv = 1'b0;
    check("reload_abort_busy", int'(a_busy), 0);
  endtask

  task automatic t_enable_gaps();
    bit en_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int exp_q[7]  = '{3, 3, 3, 2, 1, 1, 0};
    do_load(0, 4, 0);
    check("gaps_load_q", int'(a_q), 4);
    tc_cnt4 = 0;
    for (int i = 0; i < 7; i++) begin
      edge4(en_pat[i], 0);
      check("gaps_q", int'(a_q), exp_q[i]);
    end
    edge4(1, 0);
    check("gaps_tc_count", tc_cnt4, 1);
  endtask

  task automatic t_abort_collision();
    do_load(0, 2, 0);
    edge4(1, 0);
    check("abort_pre_q", int'(a_q), 1);
    tc_cnt4 = 0;
    edge4(1, 1);
    check("abort_q", int'(a_q), 0);
    check("abort_tc", int'(a_tc), 0);
    check("abort_done", int'(a_done), 0);
    check("abort_state", int'(a_st), 0);
    edge4(1, 0);
    check("abort_tc_count", tc_cnt4, 0);
  endtask

  task automatic t_zero_and_wrap();
    int edges;
    do_load(0, 0, 1);
    check("zero_tc", int'(a_tc), 1);
    check("zero_done", int'(a_done), 1);
    edge4(1, 0);
    check("zero_no_reload_q", int'(a_q), 0);
    check("zero_tc_once", int'(a_tc), 0);
    check("zero_done_hold", int'(a_done), 1);
    edge4(0, 1);
    b_en = 1'b1;
    do_load(1, 255, 0);
    check("wrap_load_q", int'(b_q), 255);
    edges = 0;
    for (int i = 0; i < 300 && !b_tc; i++) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("wrap_edges", edges, 255);
    check("wrap_q", int'(b_q), 0);
  endtask

  task automatic t_random(input int cycles);
    bit a_pend, b_pend;
    a_pend = 1'b0;
    b_pend = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (a_pend) a_lv = 1'b0;
      if (b_pend) b_lv = 1'b0;
      if (!a_lv && $urandom_range(0, 99) < 20) begin
        a_lv = 1'b1; a_val = 4'($urandom_range(0, 15)); a_mode = 1'($urandom_range(0, 1));
      end
      if (!b_lv && $urandom_range(0, 99) < 15) begin
        b_lv = 1'b1; b_val = 8'($urandom_range(0, 40)); b_mode = 1'($urandom_range(0, 1));
      end
      a_en    = ($urandom_range(0, 99) < 80);
      b_en    = ($urandom_range(0, 99) < 80);
      a_abort = !a_lv && ($urandom_range(0, 99) < 5);
      b_abort = !b_lv && ($urandom_range(0, 99) < 4);
      a_pend  = a_lv && a_ready;
      b_pend  = b_lv && b_ready;
      @(posedge clk);
      #1;
    end
    a_lv = 1'b0; b_lv = 1'b0; a_abort = 1'b0; b_abort = 1'b0;
  endtask

  initial begin
    a_lv = 1'b0; a_val = '0; a_mode = 1'b0; a_en = 1'b0; a_abort = 1'b0;
    b_lv = 1'b0; b_val = '0; b_mode = 1'b0; b_en = 1'b0; b_abort = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_q", int'(a_q), 0);
    check("rst_ready", int'(a_ready), 1);
    check("rst_done", int'(a_done), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    t_reset_mid();
    t_one_shot();
    t_auto_reload();
    t_enable_gaps();
    t_abort_collision();
    t_zero_and_wrap();
    t_random(2000);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_count_timer.md
# down_count_timer

Programmable down-counter with load handshake, terminal-count pulse and optional auto-reload. It is the counting-down counterpart to the team's ripple up-counter: the up-counter measures elapsed ticks from zero, and this block counts a loaded value back down to zero and flags expiry. It updates on the same clock edge as the up-counter, so the two can share a clock domain. It serves as the timeout/interval source for control logic.

## Interface
- WIDTH, 4: counter width in bits (legal range 2..16).

- clk  in  1  counter clock; all state updates on the falling edge.
- reset  in  1  reset, asynchronous, active-high.
- load_valid  in  1  load request; held until accepted.
- load_ready  out  1  high when a load can be accepted.
- load_value  in  WIDTH  start count; sampled on handshake.
- load_mode  in  1  0 = one-shot, 1 = auto-reload; sampled on handshake.
- enable  in  1  count enable; low freezes the count.
- abort  in  1  cancel the current count.
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered, one cycle).
- busy  out  1  high while counting.
- done  out  1  high after a one-shot run expires, until the next load or abort.

## Operation
- States: IDLE, COUNT, DONE. Encoding is free.
- Reset (async, any time, including mid-count):
  - state=IDLE, q=0, tc=0, reload register=0, mode=0.
  - busy=0, done=0, load_ready=1.
- load_ready = (state != COUNT). A load is accepted when load_valid & load_ready are high at a falling edge.
- IDLE or DONE with load accepted:
  - q<=load_value, reload<=load_value, mode<=load_mode.
  - If load_value != 0: next state = COUNT.
  - If load_value == 0: tc<=1, next state = DONE, mode forced to one-shot.
- COUNT, at each falling edge, first match wins:
  1. abort: q<=0, state=IDLE, tc stays 0.
  2. enable=0: hold q; tc<=0.
  3. q>1: q<=q-1.
  4. q==1: q<=0, tc<=1.
  5. q==0 and mode=1: q<=reload; stay in COUNT.
  6. q==0 and mode=0: this case is unreachable, because one-shot exits on the tc edge (see next rule).
- One-shot expiry: on the edge where q goes 1->0 with mode=0, the state moves to DONE in the same edge.
- Auto-reload: the state remains COUNT with q=0 for one enabled edge, then reloads. The period is N+1 enabled edges for a load of N.
- DONE:
  - done=1, q holds 0.
  - abort -> IDLE (done clears).
  - An accepted load behaves as from IDLE.
- Default: tc<=0 on every edge not listed above as setting tc, so tc is exactly one clock wide.
- Arithmetic: unsigned modulo 2^WIDTH. No underflow path exists, because decrement only applies when q>1.
- Loads presented during COUNT are not accepted. load_valid must be held by the source.
- busy = (state==COUNT). done = (state==DONE). Both are decoded from the state register.

## Timing
- Load-to-count latency: q shows load_value after the accepting edge. The first decrement happens on the next enabled edge.
- One-shot with load N (N>0) and enable held high: tc is high during the cycle following edge N after the load, and q=0 then. done rises on that same edge.
- Auto-reload: tc pulses every N+1 enabled edges. q sequence: N, N-1, ..., 1, 0, N, ...
- enable low while q==0 in auto-reload: the block holds at 0 and tc does not repeat.
- abort has priority over decrement, reload and tc on the same edge. If abort coincides with q 1->0, no tc is emitted.
- reset deassertion takes effect at the next falling edge, with no extra synchronisation inside the block.

## Test plan
- Reset mid-count:
  - Stimulus: load 9, let q reach 6, pulse reset.
  - Response: q=0, busy=0, tc=0, load_ready=1 immediately (asynchronous). No tc follows afterwards.
- One-shot:
  - Stimulus: load 5, mode 0, enable=1.
  - Response: q=5,4,3,2,1,0 on successive edges. A single tc pulse occurs with q=0. done=1 from that edge, busy=0, load_ready=1.
- Auto-reload:
  - Stimulus: load 3, mode 1, enable=1 for 12 edges.
  - Response: q=3,2,1,0,3,2,1,0,3,... with tc once every 4 edges. load_valid stays unaccepted throughout.
- Enable gaps:
  - Stimulus: load 4, toggle enable 1,0,0,1,1,0,1,1.
  - Response: q decrements only on enabled edges (4,3,3,3,2,1,1,0). tc occurs once.
- Abort collision:
  - Stimulus: load 2, assert abort on the edge where q would go 1->0.
  - Response: q=0, state IDLE, tc stays 0, done=0.
- Zero load and WIDTH=8 wrap:
  - Stimulus (zero load): load 0 with mode 1.
  - Response: tc pulses once, done=1, no reload.
  - Stimulus (wrap): WIDTH=8, load 255.
  - Response: tc after exactly 255 enabled edges.
